// File: rtl/detector_pkg.sv
// -----------------------------------------------------------------------------
// detector_pkg
//   Definitions shared by the serial zero-detector slice: the feeder FSM state
//   encoding and the default level driven on the serial line between words.
// -----------------------------------------------------------------------------
package detector_pkg;

  // Feeder FSM encoding. The values are fixed so that waveform viewers and the
  // downstream checkers can decode the state bits directly.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10
  } feeder_state_e;

  // Serial line level when no data bit is being presented.
  localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage : detector_pkg

// File: rtl/serial_bit_feeder_if.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder_if
//   Bundles the word handshake and the serial output of serial_bit_feeder.
//   Signals:
//     data_in    [WIDTH]  parallel word, stable while data_valid is high
//     data_valid          source has a word
//     data_ready          feeder takes the word on this edge if data_valid
//     x_out               serial bit toward the detector x_in
//     bit_valid           x_out carries a live data bit
//     word_done           pulse with the LSB of each word
//     busy                feeder is not idle
//   Modports:
//     master  word source and serial sink (testbench / upstream logic)
//     slave   the feeder itself
// -----------------------------------------------------------------------------
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             x_out;
  logic             bit_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output data_in, data_valid,
    input  data_ready, x_out, bit_valid, word_done, busy
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, x_out, bit_valid, word_done, busy
  );

endinterface : serial_bit_feeder_if

// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
//   Parallel-to-serial stage for the serial zero-detector FSMs. Accepts WIDTH-bit
//   words on a valid/ready handshake and shifts each one out MSB-first, one bit
//   per clock, on a registered x_out qualified by bit_valid. GAP idle cycles at
//   IDLE_BIT separate consecutive words; GAP=0 streams words back to back.
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous, active-high; drops any word in flight
//     bus    serial_bit_feeder_if.slave (handshake in, serial stream out)
// -----------------------------------------------------------------------------
module serial_bit_feeder
  import detector_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   GAP      = 1,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_bit_feeder_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);
  // gap_cnt keeps one bit even when GAP=0 so the declaration stays legal; it is
  // never loaded in that configuration.
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  feeder_state_e    state_q,     state_d;
  logic [WIDTH-1:0] shift_q,     shift_d;
  logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
  logic             x_out_q,     x_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             word_done_q, word_done_d;

  logic data_ready;
  logic accept;

  // Ready in IDLE, and on the last bit of a word when there is no gap so the
  // next word's MSB follows the current LSB with no bubble.
  assign data_ready = (state_q == S_IDLE) ||
                      ((state_q == S_SHIFT) && (bit_cnt_q == '0) && (GAP == 0));
  assign accept     = bus.data_valid && data_ready;

  // bit_cnt_q counts the bits still to be presented after the one on x_out, so
  // it reaches 0 while the LSB is on the line and the reload/exit decision is
  // taken there.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would make synthesis infer a latch to hold its old value.
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    x_out_d     = IDLE_BIT;
    bit_valid_d = 1'b0;
    word_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: ;  // only leaves on accept, handled below
      S_SHIFT: begin
        if (bit_cnt_q != '0) begin
          x_out_d     = shift_q[WIDTH-1];
          shift_d     = shift_q << 1;
          bit_cnt_d   = bit_cnt_q - 1'b1;
          bit_valid_d = 1'b1;
          word_done_d = (bit_cnt_q == CNT_W'(1));
        end else if (GAP > 0) begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_W'(GAP - 1);
        end else begin
          state_d = S_IDLE;  // overridden below if a new word is accepted
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d   = S_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A new word presents its MSB on the very edge it is accepted.
    if (accept) begin
      state_d     = S_SHIFT;
      x_out_d     = bus.data_in[WIDTH-1];
      shift_d     = bus.data_in << 1;
      bit_cnt_d   = CNT_W'(WIDTH - 1);
      bit_valid_d = 1'b1;
      word_done_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      x_out_q     <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      x_out_q     <= x_out_d;
      bit_valid_q <= bit_valid_d;
      word_done_q <= word_done_d;
    end
  end

  assign bus.data_ready = data_ready;
  assign bus.x_out      = x_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.word_done  = word_done_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule : serial_bit_feeder

// File: tb/tb_serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_feeder
//   Directed bench for serial_bit_feeder. dut0 uses WIDTH=8, GAP=1; dut1 uses
//   WIDTH=8, GAP=0 for back-to-back streaming. A small Mealy zero detector
//   (y=1 on a 0 that directly follows a 1) listens to dut0's x_out.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_bit_feeder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  serial_bit_feeder_if #(.WIDTH(8)) bus0 ();
  serial_bit_feeder_if #(.WIDTH(8)) bus1 ();

  serial_bit_feeder #(.WIDTH(8), .GAP(1), .IDLE_BIT(1'b0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  serial_bit_feeder #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b0)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  // Mealy zero detector fed by dut0; its reset is active-low.
  logic det_rst_n;
  logic det_prev_q;
  logic y_out;

  assign det_rst_n = ~reset;
  assign y_out     = det_prev_q & ~bus0.x_out;

  always_ff @(posedge clock or negedge det_rst_n) begin
    if (!det_rst_n) det_prev_q <= 1'b0;
    else            det_prev_q <= bus0.x_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // dut0 status vector: {x_out, bit_valid, word_done, data_ready, busy}
  function automatic logic [4:0] st0();
    return {bus0.x_out, bus0.bit_valid, bus0.word_done, bus0.data_ready, bus0.busy};
  endfunction

  function automatic logic [4:0] st1();
    return {bus1.x_out, bus1.bit_valid, bus1.word_done, bus1.data_ready, bus1.busy};
  endfunction

  // Offer a word to dut0 at a falling edge; it is accepted on the next rising
  // edge when dut0 is idle. Returns one falling edge later with valid dropped.
  task automatic send0(input logic [7:0] w);
    bus0.data_in    = w;
    bus0.data_valid = 1'b1;
    check("send0_ready", 32'(bus0.data_ready), 32'd1);
    tick();
    bus0.data_valid = 1'b0;
  endtask

  // Check n bits of w on dut0 (GAP=1, so data_ready stays 0 while shifting).
  // When inj_at >= 0, a new word inj_w is offered right after bit inj_at.
  task automatic expect_bits0(input string tag, input logic [7:0] w, input int n,
                              input int inj_at, input logic [7:0] inj_w);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_bit%0d", tag, i), 32'(st0()),
            32'({w[7-i], 1'b1, (i == 7), 1'b0, 1'b1}));
      if (i == inj_at) begin
        bus0.data_in    = inj_w;
        bus0.data_valid = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    bus0.data_in = '0; bus0.data_valid = 1'b0;
    bus1.data_in = '0; bus1.data_valid = 1'b0;

    // 1. Reset held for 3 cycles: idle line, ready, not busy.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_hold%0d", i), 32'(st0()), 32'b00010);
    end
    reset = 1'b0;
    tick();
    check("after_rst", 32'(st0()), 32'b00010);

    // 2. 8'hB2 -> 1,0,1,1,0,0,1,0, word_done on the LSB, one gap cycle, ready.
    send0(8'hB2);
    expect_bits0("b2", 8'hB2, 8, -1, 8'h00);
    check("b2_gap", 32'(st0()), 32'b00001);
    tick();
    check("b2_idle", 32'(st0()), 32'b00010);

    // 3. GAP=0: FF then 00 with data_valid held high -> 16 contiguous bits,
    //    ready only on each LSB.
    bus1.data_in    = 8'hFF;
    bus1.data_valid = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("stream_bit%0d", i), 32'(st1()),
            32'({(i < 8), 1'b1, (i % 8 == 7), (i % 8 == 7), 1'b1}));
      if (i == 7)  bus1.data_in    = 8'h00;
      if (i == 15) bus1.data_valid = 1'b0;
      tick();
    end
    check("stream_idle", 32'(st1()), 32'b00010);

    // 4. Word offered mid-shift is held off until dut0 is idle again.
    send0(8'h3C);
    expect_bits0("hold_a", 8'h3C, 8, 2, 8'hC3);
    check("hold_gap", 32'(st0()), 32'b00001);
    tick();
    check("hold_idle_ready", 32'(st0()), 32'b00010);
    tick();
    bus0.data_valid = 1'b0;
    expect_bits0("hold_b", 8'hC3, 8, -1, 8'h00);
    tick();
    tick();

    // 5. Async reset after the 3rd bit of A5 (that bit is a 1).
    send0(8'hA5);
    expect_bits0("rst_a5", 8'hA5, 2, -1, 8'h00);
    check("rst_a5_bit2", 32'(st0()), 32'b11001);
    #2 reset = 1'b1;
    #1 check("rst_async", 32'(st0()), 32'b00010);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rst_quiet%0d", i), 32'(st0()), 32'b00010);
    end

    // 6. Detector on 8'b0111_0110: y_out on bits 4 and 7.
    send0(8'b0111_0110);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("det_bit%0d", i), 32'({bus0.bit_valid, y_out}),
            32'({1'b1, (i == 4) || (i == 7)}));
      tick();
    end
    check("det_gap", 32'({bus0.bit_valid, y_out}), 32'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_bit_feeder
